// File: rtl/fu_exec_unit.sv
// rtl/fu_exec_unit.sv - single reservation-station execution slot (ALU or load/store)
module fu_exec_unit #(
   parameter int ALU_LATENCY = 1,
   parameter int DATA_W      = 32,
   parameter int TAG_W       = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic              issue_is_ls,
   input  logic              issue_alusrc,
   input  logic [3:0]        issue_alu_type,
   input  logic [TAG_W-1:0]  issue_rd_tag,
   input  logic [TAG_W-1:0]  issue_rob_num,
   input  logic [DATA_W-1:0] issue_rs1_val,
   input  logic [DATA_W-1:0] issue_rs2_val,
   input  logic [DATA_W-1:0] issue_imm,
   output logic              fu_ready,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [DATA_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              wb_valid,
   output logic [TAG_W-1:0]  wb_tag,
   output logic [DATA_W-1:0] wb_val,
   output logic              cmpl_valid,
   output logic [TAG_W-1:0]  cmpl_rob_num,
   output logic              issue_drop_err
);

   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY - 1);
   localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
                          OP_XOR = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8,
                          OP_SLT = 4'd9, OP_SLTU = 4'd10, OP_PASS_B = 4'd11;
   localparam logic [3:0] LS_SW = 4'd2;

   state_t              state, state_nxt;
   logic [3:0]          cnt;
   logic                op_is_ls, op_alusrc, wb_en;
   logic [3:0]          op_type;
   logic [TAG_W-1:0]    op_rd, op_rob;
   logic [DATA_W-1:0]   op_a, op_rs2, op_imm;
   logic [DATA_W-1:0]   operand_b, alu_result;
   logic [4:0]          shamt;

   assign operand_b = op_alusrc ? op_imm : op_rs2;
   assign shamt     = operand_b[4:0];

   always_comb begin
      alu_result = '0;
      case (op_type)
         OP_ADD:    alu_result = op_a + operand_b;
         OP_SUB:    alu_result = op_a - operand_b;
         OP_AND:    alu_result = op_a & operand_b;
         OP_OR:     alu_result = op_a | operand_b;
         OP_XOR:    alu_result = op_a ^ operand_b;
         OP_SLL:    alu_result = op_a << shamt;
         OP_SRL:    alu_result = op_a >> shamt;
         OP_SRA:    alu_result = $signed(op_a) >>> shamt;
         OP_SLT:    alu_result = DATA_W'($signed(op_a) < $signed(operand_b));
         OP_SLTU:   alu_result = DATA_W'(op_a < operand_b);
         OP_PASS_B: alu_result = operand_b;
         default:   alu_result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (issue_valid) state_nxt = S_EXEC;
         S_EXEC:     if (cnt == 4'd0) state_nxt = op_is_ls ? S_MEM_REQ : S_WB;
         S_MEM_REQ:  if (mem_req_ready) state_nxt = S_MEM_WAIT;
         S_MEM_WAIT: if (mem_resp_valid) state_nxt = S_WB;
         S_WB:       state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      fu_ready      = (state == S_IDLE);
      mem_req_valid = (state == S_MEM_REQ);
      cmpl_valid    = (state == S_WB);
      wb_valid      = (state == S_WB) && wb_en;
   end

   // wb_en carries the "broadcast this op" decision into WB: never for x0 or stores
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0; op_is_ls <= 1'b0; op_alusrc <= 1'b0; op_type <= '0;
         op_rd <= '0; op_rob <= '0; op_a <= '0; op_rs2 <= '0; op_imm <= '0;
         wb_en <= 1'b0; wb_tag <= '0; wb_val <= '0; cmpl_rob_num <= '0;
         mem_req_we <= 1'b0; mem_req_addr <= '0; mem_req_wdata <= '0;
         issue_drop_err <= 1'b0;
      end else begin
         if (issue_valid && state != S_IDLE) issue_drop_err <= 1'b1;
         case (state)
            S_IDLE: if (issue_valid) begin
               op_is_ls <= issue_is_ls;    op_alusrc <= issue_alusrc;
               op_type  <= issue_alu_type; op_rd     <= issue_rd_tag;
               op_rob   <= issue_rob_num;  op_a      <= issue_rs1_val;
               op_rs2   <= issue_rs2_val;  op_imm    <= issue_imm;
               cnt      <= CNT_INIT;
            end
            S_EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (op_is_ls) begin
                  mem_req_addr  <= op_a + op_imm;
                  mem_req_wdata <= op_rs2;
                  mem_req_we    <= (op_type == LS_SW);
               end else begin
                  wb_val       <= alu_result;
                  wb_tag       <= op_rd;
                  cmpl_rob_num <= op_rob;
                  wb_en        <= (op_rd != '0);
               end
            end
            S_MEM_WAIT: if (mem_resp_valid) begin
               if (!mem_req_we) wb_val <= mem_resp_data;
               wb_tag       <= op_rd;
               cmpl_rob_num <= op_rob;
               wb_en        <= !mem_req_we && (op_rd != '0);
            end
            default: ;
         endcase
      end
   end

endmodule
